// File: rtl/cdc_fifo_w8r16.sv
// Byte-in / word-out FIFO for the audio datapath.
// An 8-bit producer writes bytes; a 16-bit consumer reads them back in pairs.
// The first byte of each pair becomes the upper half of the word.
// Fill levels and flags come straight from the registered pointers.
// All of them therefore reflect an operation from just after the edge that accepted it.
module cdc_fifo_w8r16 #(
  parameter int WR_DEPTH_WIDTH   = 12,
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RD_DEPTH_WIDTH   = 11,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int RD_DEPTH = 1 << RD_DEPTH_WIDTH;
  localparam logic [WR_DEPTH_WIDTH:0] AF_LEVEL = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
  localparam logic [RD_DEPTH_WIDTH:0] AE_LEVEL = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

  // The byte pointer carries one extra bit over the byte address.
  // The word pointer carries one extra bit over the word address.
  // This lets a full FIFO be told apart from an empty one.
  logic [WR_DEPTH_WIDTH:0]    wr_ptr;
  logic [RD_DEPTH_WIDTH:0]    rd_ptr;
  logic [WR_DEPTH_WIDTH:0]    level;
  logic                       wr_accept;
  logic                       rd_accept;
  logic [RD_DEPTH_WIDTH-1:0]  wr_word_addr;
  logic [RD_DEPTH_WIDTH-1:0]  rd_word_addr;

  // Two byte banks side by side form one word.
  // bank_hi holds even bytes and bank_lo holds odd bytes.
  logic [WR_DATA_WIDTH-1:0] bank_hi [RD_DEPTH];
  logic [WR_DATA_WIDTH-1:0] bank_lo [RD_DEPTH];

  // The stored byte count is the distance between the byte pointer and the word pointer scaled to bytes.
  // It never exceeds 2**WR_DEPTH_WIDTH, so the top bit alone marks full.
  assign level          = wr_ptr - {rd_ptr, 1'b0};
  assign wr_water_level = level;
  assign rd_water_level = level[WR_DEPTH_WIDTH:1];
  assign wr_full        = level[WR_DEPTH_WIDTH];
  assign rd_empty       = (level[WR_DEPTH_WIDTH:1] == '0);
  assign almost_full    = (level >= AF_LEVEL);
  assign almost_empty   = (rd_water_level <= AE_LEVEL);

  assign wr_accept    = wr_en & ~wr_full;
  assign rd_accept    = rd_en & ~rd_empty;
  assign wr_word_addr = wr_ptr[WR_DEPTH_WIDTH-1:1];
  assign rd_word_addr = rd_ptr[RD_DEPTH_WIDTH-1:0];

  // Byte pointer: advances on every accepted write and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Word pointer: advances on every accepted read and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (rd_accept) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage writes are steered by the low pointer bit.
  // The banks are plain RAM with no reset.
  // An accepted read needs a complete word, so it can never target the word currently being written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (!wr_ptr[0]) begin
        bank_hi[wr_word_addr] <= wr_data;
      end else begin
        bank_lo[wr_word_addr] <= wr_data;
      end
    end
  end

  // Read data register: loads on an accepted read and otherwise holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_accept) begin
      rd_data <= {bank_hi[rd_word_addr], bank_lo[rd_word_addr]};
    end
  end

endmodule

// File: tb/tb_cdc_fifo_w8r16.sv
// Self-checking bench for cdc_fifo_w8r16.
// A byte queue stands in for the FIFO contents.
// Expected flags and levels follow from the queue length.
module tb_cdc_fifo_w8r16;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        rd_en;
  logic        wr_full;
  logic [12:0] wr_water_level;
  logic        almost_full;
  logic [15:0] rd_data;
  logic        rd_empty;
  logic [11:0] rd_water_level;
  logic        almost_empty;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q [$];
  logic [15:0] exp_rd;
  logic [28:0] dut_stat;

  assign dut_stat = {wr_full, almost_full, rd_empty, almost_empty, wr_water_level, rd_water_level};

  cdc_fifo_w8r16 dut (
    .clk            (clk),
    .rst_n          (tb_rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  // Expected {wr_full, almost_full, rd_empty, almost_empty, wr_level, rd_level} for n stored bytes.
  function automatic logic [28:0] exp_stat(input int n);
    logic [12:0] wl;
    logic [11:0] rl;
    wl = 13'(n);
    rl = 12'(n / 2);
    return {n == 4096, n >= 1020, n < 2, (n / 2) <= 4, wl, rl};
  endfunction

  // One clock cycle of stimulus.
  // The model acts on the state from before the edge.
  // The task returns 1 ns after the edge, ready for sampling.
  task automatic step(input logic we, input logic [7:0] d, input logic re);
    bit         full;
    bit         empty;
    logic [7:0] b0;
    logic [7:0] b1;
    wr_en   = we;
    wr_data = d;
    rd_en   = re;
    full    = (q.size() == 4096);
    empty   = (q.size() < 2);
    @(posedge clk);
    if (re && !empty) begin
      b0 = q.pop_front();
      b1 = q.pop_front();
      exp_rd = {b0, b1};
    end
    if (we && !full) q.push_back(d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic reset_dut();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    tb_rst  = 1'b0;
    #200;
    tb_rst  = 1'b1;
    q.delete();
    exp_rd  = 16'h0000;
    #10;
  endtask

  task automatic test_reset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    tb_rst  = 1'b0;
    #200;
    total++;
    if (dut_stat !== exp_stat(0)) begin
      bad++;
      $display("FAIL reset_stat got=%h exp=%h", dut_stat, exp_stat(0));
    end
    total++;
    if (rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rd_data got=%h exp=0000", rd_data);
    end
    tb_rst = 1'b1;
    q.delete();
    exp_rd = 16'h0000;
    #10;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4097; i++) begin
      step(1'b1, 8'hFF - 8'(i), 1'b0);
      total++;
      if (dut_stat !== exp_stat(q.size())) begin
        bad++;
        $display("FAIL fill_stat[%0d] got=%h exp=%h", i, dut_stat, exp_stat(q.size()));
      end
      if (i == 1018 || i == 1019) begin
        total++;
        if (almost_full !== (i == 1019)) begin
          bad++;
          $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, i == 1019);
        end
      end
      if (i >= 4095) begin
        total++;
        if ({wr_full, wr_water_level, rd_water_level} !== {1'b1, 13'd4096, 12'd2048}) begin
          bad++;
          $display("FAIL fill_full[%0d] got=%b/%0d/%0d exp=1/4096/2048", i, wr_full, wr_water_level, rd_water_level);
        end
      end
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 2049; k++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if (rd_data !== exp_rd) begin
        bad++;
        $display("FAIL drain_data[%0d] got=%h exp=%h", k, rd_data, exp_rd);
      end
      total++;
      if (dut_stat !== exp_stat(q.size())) begin
        bad++;
        $display("FAIL drain_stat[%0d] got=%h exp=%h", k, dut_stat, exp_stat(q.size()));
      end
    end
    total++;
    if (rd_data !== 16'h0100) begin
      bad++;
      $display("FAIL drain_last got=%h exp=0100", rd_data);
    end
  endtask

  task automatic test_odd();
    reset_dut();
    step(1'b1, 8'hA5, 1'b0);
    total++;
    if (dut_stat !== exp_stat(1)) begin
      bad++;
      $display("FAIL odd_stat1 got=%h exp=%h", dut_stat, exp_stat(1));
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if ({rd_data, wr_water_level, rd_empty} !== {16'h0000, 13'd1, 1'b1}) begin
      bad++;
      $display("FAIL odd_read_ignored got=%h/%0d/%b exp=0000/1/1", rd_data, wr_water_level, rd_empty);
    end
    step(1'b1, 8'h5A, 1'b0);
    total++;
    if (rd_empty !== 1'b0) begin
      bad++;
      $display("FAIL odd_empty_fall got=%b exp=0", rd_empty);
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (rd_data !== 16'hA55A) begin
      bad++;
      $display("FAIL odd_word got=%h exp=a55a", rd_data);
    end
  endtask

  task automatic test_concurrent();
    reset_dut();
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
    total++;
    if (dut_stat !== exp_stat(10)) begin
      bad++;
      $display("FAIL conc_pre got=%h exp=%h", dut_stat, exp_stat(10));
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      total++;
      if (rd_data !== exp_rd) begin
        bad++;
        $display("FAIL conc_data[%0d] got=%h exp=%h", i, rd_data, exp_rd);
      end
      total++;
      if (dut_stat !== exp_stat(q.size())) begin
        bad++;
        $display("FAIL conc_stat[%0d] got=%h exp=%h", i, dut_stat, exp_stat(q.size()));
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom));
      total++;
      if (rd_data !== exp_rd || dut_stat !== exp_stat(q.size())) begin
        bad++;
        $display("FAIL rand[%0d] got=%h/%h exp=%h/%h", i, rd_data, dut_stat, exp_rd, exp_stat(q.size()));
      end
    end
  endtask

  task automatic test_full_concurrent();
    reset_dut();
    for (int i = 0; i < 4096; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b1);
    total++;
    if (wr_water_level !== 13'd4094 || rd_data !== exp_rd) begin
      bad++;
      $display("FAIL full_rw got=%0d/%h exp=4094/%h", wr_water_level, rd_data, exp_rd);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < 2048; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b1);
    total++;
    if (dut_stat !== exp_stat(q.size())) begin
      bad++;
      $display("FAIL mid_pre got=%h exp=%h", dut_stat, exp_stat(q.size()));
    end
    #3;
    tb_rst = 1'b0;
    #1;
    q.delete();
    exp_rd = 16'h0000;
    total++;
    if (dut_stat !== exp_stat(0) || rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL mid_async got=%h/%h exp=%h/0000", dut_stat, rd_data, exp_stat(0));
    end
    #20;
    tb_rst = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (dut_stat !== exp_stat(0) || rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL mid_read_empty got=%h/%h exp=%h/0000", dut_stat, rd_data, exp_stat(0));
    end
    step(1'b1, 8'h3C, 1'b1);
    total++;
    if (dut_stat !== exp_stat(1) || rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL mid_rw_empty got=%h/%h exp=%h/0000", dut_stat, rd_data, exp_stat(1));
    end
  endtask

  initial begin
    tb_rst  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    exp_rd  = 16'h0000;
    test_reset();
    test_fill();
    test_drain();
    test_odd();
    test_concurrent();
    test_random();
    test_full_concurrent();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
